// File: rtl/fir_pkg.sv
// Shared FIR arithmetic types and helpers: arbiter state encoding and the
// fractional multiply used by every FIR datapath in this slice.
package fir_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAC_BITS_DEF  = 10;
  localparam int MUL_W          = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } arb_state_t;

  // Operands arrive sign-extended to MUL_W, so the double-width product is
  // exact for any DATA_WIDTH up to MUL_W; callers keep the low bits they need.
  function automatic logic signed [MUL_W-1:0] mul_frac(
    input logic signed [MUL_W-1:0] a,
    input logic signed [MUL_W-1:0] b,
    input int                      frac
  );
    logic signed [2*MUL_W-1:0] p;
    p = a * b;
    p = p >>> frac;
    return p[MUL_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request after ptr, wrapping,
// returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fir_mac_arbiter.sv
// One fixed-point MAC shared by NUM_REQ FIR channels: round-robin burst grants,
// one term per cycle, accumulated sum returned over a per-channel handshake.
module fir_mac_arbiter
  import fir_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int MAX_OPS    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b,
  input  logic [NUM_REQ-1:0]            op_valid,
  input  logic [NUM_REQ-1:0]            op_last,
  output logic [NUM_REQ-1:0]            op_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [NUM_REQ-1:0]            res_valid,
  input  logic [NUM_REQ-1:0]            res_ready,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OPS + 1);

  arb_state_t                    state;
  logic [IDX_W-1:0]              ptr;
  logic [IDX_W-1:0]              gidx;
  logic [IDX_W-1:0]              arb_idx;
  logic [NUM_REQ-1:0]            arb_gnt;
  logic [CNT_W-1:0]              op_cnt;
  logic signed [DATA_WIDTH-1:0]  acc_p0;
  logic signed [DATA_WIDTH-1:0]  a_sel;
  logic signed [DATA_WIDTH-1:0]  b_sel;
  logic signed [DATA_WIDTH-1:0]  prod;
  logic                          xfer;
  logic                          last_term;
  logic                          cnt_full;

  // Truncate the shared wide fractional product back to the datapath width;
  // the accumulator then wraps naturally with no saturation.
  function automatic logic signed [DATA_WIDTH-1:0] frac_product(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [MUL_W-1:0] wide;
    wide = mul_frac(MUL_W'(a), MUL_W'(b), FRAC_BITS);
    return wide[DATA_WIDTH-1:0];
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        a_sel = op_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel = op_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign prod      = frac_product(a_sel, b_sel);
  assign op_ready  = grant & {NUM_REQ{state == ACCUM}};
  assign xfer      = op_valid[gidx] & op_ready[gidx];
  assign last_term = op_last[gidx];
  assign cnt_full  = (op_cnt == CNT_W'(MAX_OPS - 1));
  assign res_data  = acc_p0;
  assign busy      = (state != IDLE);

  // Stage 0: burst controller, accumulator and term counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      res_valid <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      gidx      <= '0;
      acc_p0    <= '0;
      op_cnt    <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant  <= arb_gnt;
            gidx   <= arb_idx;
            acc_p0 <= '0;
            op_cnt <= '0;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_p0 <= acc_p0 + prod;
            op_cnt <= op_cnt + 1'b1;
            // A last term on the MAX_OPS-th transfer is a normal close.
            if (last_term || cnt_full) begin
              state     <= RESULT;
              res_valid <= grant;
              if (!last_term) overrun <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (res_ready[gidx]) begin
            ptr       <= gidx;
            grant     <= '0;
            res_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_arbiter.sv
// Scoreboard bench for fir_mac_arbiter: a driver streams bursts and queues the
// expected sums; an independent monitor checks each accepted result.
module tb_fir_mac_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int FB = 10;
  localparam int MO = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req, op_valid, op_last, op_ready, grant, res_valid, res_ready;
  logic [N*DW-1:0] op_a, op_b;
  logic [DW-1:0]   res_data;
  logic            busy, overrun;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] va[MO];
  logic [DW-1:0] vb[MO];
  bit            ovr_model;

  always #5 clock = ~clock;

  fir_mac_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .MAX_OPS    (MO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_last   (op_last),
    .op_ready  (op_ready),
    .grant     (grant),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference term: exact signed product, arithmetic shift, keep DW bits.
  function automatic logic [DW-1:0] ref_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> FB;
    return p[DW-1:0];
  endfunction

  task automatic put_op(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic v, input logic l);
    op_a[ch*DW +: DW] = a;
    op_b[ch*DW +: DW] = b;
    op_valid[ch]      = v;
    op_last[ch]       = l;
  endtask

  task automatic noise(input int ch);
    put_op(1 - ch, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_grant(input int ch, input string name);
    int n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (grant == '0) check({name, "_timeout"}, 64'(n), 64'(0));
    else             check(name, 64'(grant), 64'(1 << ch));
  endtask

  task automatic stream(input int ch, input int n, input bit use_last,
                        input bit exp_en, input logic [DW-1:0] exp_val);
    logic [DW-1:0] sum = '0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        put_op(ch, $urandom, $urandom, 1'b0, 1'b1);
        noise(ch);
        @(posedge clock); #1;
      end
      put_op(ch, va[i], vb[i], 1'b1, use_last && (i == n - 1));
      noise(ch);
      check("op_ready", 64'(op_ready), 64'(1 << ch));
      @(posedge clock); #1;
      sum += ref_term(va[i], vb[i]);
    end
    put_op(ch, '0, '0, 1'b0, 1'b0);
    put_op(1 - ch, '0, '0, 1'b0, 1'b0);
    if (!use_last && n == MO) ovr_model = 1'b1;
    sb.push_back('{ch, exp_en ? exp_val : sum});
  endtask

  task automatic finish(input int ch, input int stall);
    logic [DW-1:0] d;
    check("res_valid_lat", 64'(res_valid), 64'(1 << ch));
    check("busy_result", 64'(busy), 64'(1));
    d = res_data;
    for (int s = 0; s < stall; s++) begin
      res_ready[1-ch] = 1'b1;
      put_op(ch, $urandom, $urandom, 1'b1, 1'b0);
      @(posedge clock); #1;
      check("res_hold_valid", 64'(res_valid), 64'(1 << ch));
      check("res_hold_data", 64'(res_data), 64'(d));
      check("res_hold_grant", 64'(grant), 64'(1 << ch));
    end
    res_ready[1-ch] = 1'b0;
    put_op(ch, '0, '0, 1'b0, 1'b0);
    res_ready[ch] = 1'b1;
    @(posedge clock); #1;
    res_ready[ch] = 1'b0;
    check("accept_valid", 64'(res_valid), 64'(0));
    check("accept_grant", 64'(grant), 64'(0));
    check("accept_busy", 64'(busy), 64'(0));
    check("overrun", 64'(overrun), 64'(ovr_model));
  endtask

  task automatic burst(input int ch, input int n, input bit use_last, input int stall,
                       input bit exp_en, input logic [DW-1:0] exp_val);
    req[ch] = 1'b1;
    wait_grant(ch, "burst_grant");
    req[ch] = 1'b0;
    stream(ch, n, use_last, exp_en, exp_val);
    finish(ch, stall);
  endtask

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (res_valid & res_ready) != '0) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 64'(res_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("sb_data", 64'(res_data), 64'(e.data));
        check("sb_chan", 64'(res_valid), 64'(1 << e.ch));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    req = '0; op_valid = '0; op_last = '0; op_a = '0; op_b = '0; res_ready = '0;
    ovr_model = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_op_ready", 64'(op_ready), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Fairness: both channels requesting continuously.
    req = 2'b11;
    for (int r = 0; r < 3; r++) begin
      wait_grant(r % 2, "fair_grant");
      va[0] = 32'h400; vb[0] = 32'($urandom_range(0, 1000));
      stream(r % 2, 1, 1'b1, 1'b0, '0);
      finish(r % 2, 0);
    end
    req = 2'b00;

    // Unity coefficient, ramp samples: 1+2+...+20.
    for (int i = 0; i < 20; i++) begin va[i] = 32'h400; vb[i] = 32'(i + 1); end
    burst(0, 20, 1'b1, 0, 1'b1, 32'h0000_00D2);

    va[0] = 32'hFFFF_FFD3; vb[0] = 32'h400;
    burst(0, 1, 1'b1, 0, 1'b1, 32'hFFFF_FFD3);
    va[0] = 32'h257; vb[0] = 32'h400;
    burst(0, 1, 1'b1, 0, 1'b1, 32'h0000_0257);

    // Held result while the other channel waits.
    req[0] = 1'b1;
    wait_grant(0, "hold_grant");
    req[0] = 1'b0;
    req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    stream(0, 4, 1'b1, 1'b0, '0);
    finish(0, 5);
    @(posedge clock); #1;
    check("hold_next_grant", 64'(grant), 64'(2'b10));
    req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    stream(1, 3, 1'b1, 1'b0, '0);
    finish(1, 0);

    // Last on exactly the MAX_OPS-th term: normal close.
    for (int i = 0; i < MO; i++) begin va[i] = 32'h400; vb[i] = 32'h1; end
    burst(1, MO, 1'b1, 1, 1'b1, 32'h20);
    // No last: forced close with overrun.
    burst(0, MO, 1'b0, 0, 1'b1, 32'h20);
    va[0] = 32'h800; vb[0] = 32'h3;
    burst(1, 1, 1'b1, 0, 1'b1, 32'h6);

    // Asynchronous reset during term 7.
    req[0] = 1'b1;
    wait_grant(0, "abort_grant");
    req[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put_op(0, 32'h400, 32'h1000, 1'b1, 1'b0);
      @(posedge clock); #1;
    end
    put_op(0, 32'h400, 32'h1000, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_grant_clr", 64'(grant), 64'(0));
    check("abort_res_valid", 64'(res_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_op_ready", 64'(op_ready), 64'(0));
    check("abort_overrun", 64'(overrun), 64'(0));
    ovr_model = 1'b0;
    put_op(0, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin va[i] = 32'h400; vb[i] = 32'(i + 5); end
    burst(0, 3, 1'b1, 0, 1'b1, 32'h12);

    // Randomized bursts.
    for (int t = 0; t < 40; t++) begin
      int  ch, n;
      bit  ul;
      ch = $urandom_range(0, 1);
      n  = ($urandom_range(0, 4) == 0) ? MO : $urandom_range(1, MO);
      ul = (n < MO) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          va[i] = $urandom; vb[i] = $urandom;
        end else begin
          va[i] = 32'($signed(32'($urandom_range(0, 4095))) - 2048);
          vb[i] = 32'($signed(32'($urandom_range(0, 65535))) - 32768);
        end
      end
      burst(ch, n, ul, $urandom_range(0, 3), 1'b0, '0);
    end

    repeat (3) @(posedge clock);
    #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
